// File: rtl/sd_spi_master.sv
// Byte-wide SPI mode-0 master for the SD-card port, mapped as four registers on the 8-bit peripheral bus.
// The transfer engine, register file and bus read mux all live in this module.
module sd_spi_master #(
    parameter logic [7:0] DIV_RESET = 8'hFF
) (
    input  logic       clk,
    input  logic       nrst,
    output logic [7:0] data_out,
    input  logic [7:0] data_in,
    input  logic [5:0] addr,
    input  logic       cs,
    input  logic       oe,
    input  logic       we,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       ss_n,
    output logic       irq
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

    state_t     r_state;
    logic       r_sck;
    logic       r_mosi;
    logic       r_ss_n;
    logic [7:0] r_rx;
    logic [7:0] r_rxShift;
    logic [7:0] r_txShift;
    logic       r_done;
    logic       r_wcol;
    logic [7:0] r_spbr;
    logic [2:0] r_bitCnt;
    logic [7:0] r_cnt;

    logic w_spdrWrite;
    logic w_spdrRead;
    logic w_busy;

    assign w_spdrWrite = cs && we && (addr == 6'h00);
    assign w_spdrRead  = cs && oe && (addr == 6'h00);
    assign w_busy      = (r_state != IDLE);

    // Flag clears come first so that a done/wcol set later in this block wins on a shared edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= IDLE;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b1;
            r_ss_n    <= 1'b1;
            r_rx      <= 8'h00;
            r_rxShift <= 8'h00;
            r_txShift <= 8'h00;
            r_done    <= 1'b0;
            r_wcol    <= 1'b0;
            r_spbr    <= DIV_RESET;
            r_bitCnt  <= 3'd0;
            r_cnt     <= 8'h00;
        end else begin
            if (w_spdrRead) begin
                r_done <= 1'b0;
                r_wcol <= 1'b0;
            end
            if (cs && we && (addr == 6'h02)) begin
                r_ss_n <= data_in[0];
            end
            if (cs && we && (addr == 6'h03)) begin
                r_spbr <= data_in;
            end
            case (r_state)
                IDLE: begin
                    if (w_spdrWrite) begin
                        r_txShift <= data_in;
                        r_mosi    <= data_in[7];
                        r_bitCnt  <= 3'd0;
                        r_cnt     <= r_spbr;
                        r_state   <= LOW;
                    end
                end
                LOW: begin
                    if (r_cnt == 8'h00) begin
                        r_sck     <= 1'b1;
                        r_rxShift <= {r_rxShift[6:0], miso};
                        r_cnt     <= r_spbr;
                        r_state   <= HIGH;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                HIGH: begin
                    if (r_cnt == 8'h00) begin
                        r_sck <= 1'b0;
                        if (r_bitCnt == 3'd7) begin
                            r_rx    <= r_rxShift;
                            r_done  <= 1'b1;
                            r_mosi  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_txShift <= {r_txShift[6:0], 1'b0};
                            r_mosi    <= r_txShift[6];
                            r_bitCnt  <= r_bitCnt + 3'd1;
                            r_cnt     <= r_spbr;
                            r_state   <= LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_spdrWrite && w_busy) begin
                r_wcol <= 1'b1;
            end
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (cs && oe) begin
            case (addr)
                6'h00:   data_out = r_rx;
                6'h01:   data_out = {r_done, r_wcol, 5'b00000, w_busy};
                6'h02:   data_out = {7'b0000000, r_ss_n};
                6'h03:   data_out = r_spbr;
                default: data_out = 8'h00;
            endcase
        end
    end

    assign sck  = r_sck;
    assign mosi = r_mosi;
    assign ss_n = r_ss_n;
    assign irq  = r_done;

endmodule

// File: tb/tb_sd_spi_master.sv
// Self-checking bench for sd_spi_master: a mode-0 slave model feeds miso, and scoreboard
// queues hold the expected mosi byte (checked by the sck monitor) and expected SPDR byte (checked on read).
module tb_sd_spi_master;

    logic       clk;
    logic       nrst;
    logic [7:0] data_out;
    logic [7:0] data_in;
    logic [5:0] addr;
    logic       cs;
    logic       oe;
    logic       we;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       ss_n;
    logic       irq;

    int         testsRun  = 0;
    int         failCount = 0;

    logic [7:0] expTx[$];
    logic [7:0] expRx[$];
    logic [7:0] slaveShift = 8'h00;
    logic [7:0] monTx      = 8'h00;
    int         monBits    = 0;
    longint     lastRise   = 0;
    int         expPeriod  = 40;
    logic [7:0] rdData;

    sd_spi_master #(.DIV_RESET(8'hFF)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .data_out (data_out),
        .data_in  (data_in),
        .addr     (addr),
        .cs       (cs),
        .oe       (oe),
        .we       (we),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .ss_n     (ss_n),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Mode-0 slave: next bit appears on the falling sck edge, well before the next sampling edge.
    always @(negedge sck) begin
        slaveShift = {slaveShift[6:0], 1'b0};
        miso = slaveShift[7];
    end

    always @(posedge sck) begin
        if (monBits > 0) checkOutput("sck_period", 32'($time - lastRise), expPeriod);
        lastRise = $time;
        monTx = {monTx[6:0], mosi};
        monBits++;
        if (monBits == 8) begin
            if (expTx.size() == 0) checkOutput("tx_unexpected", 1, 0);
            else checkOutput("mosi_byte", monTx, expTx.pop_front());
            monBits = 0;
        end
    end

    task automatic busWrite(input logic [5:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic busRead(input logic [5:0] a, output logic [7:0] d);
        cs = 1'b1; oe = 1'b1; addr = a;
        #1 d = data_out;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; oe = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [5:0] a, input logic [7:0] exp);
        logic [7:0] d;
        busRead(a, d);
        checkOutput(tag, d, exp);
    endtask

    task automatic checkRead(input string tag);
        logic [7:0] d;
        busRead(6'h00, d);
        if (expRx.size() == 0) checkOutput({tag, "_rx_queue_empty"}, 1, 0);
        else checkOutput(tag, d, expRx.pop_front());
    endtask

    task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] slaveByte);
        expTx.push_back(tx);
        expRx.push_back(slaveByte);
        slaveShift = slaveByte;
        miso = slaveByte[7];
        busWrite(6'h00, tx);
    endtask

    // Holds an SPSR read on the bus so busy can be watched every cycle until irq rises.
    task automatic waitDone(input int expCycles, input string tag);
        int cycles = 0;
        bit busyLow = 1'b0;
        cs = 1'b1; oe = 1'b1; addr = 6'h01;
        #1;
        while (!irq && cycles < 20000) begin
            if (!data_out[0]) busyLow = 1'b1;
            @(negedge clk);
            cycles++;
        end
        cs = 1'b0; oe = 1'b0;
        checkOutput({tag, "_irq"}, irq, 1);
        checkOutput({tag, "_busy_dropped"}, busyLow, 0);
        if (expCycles >= 0) checkOutput({tag, "_cycles"}, cycles, expCycles);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: got 1, expected 0");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        nrst = 1'b0; cs = 1'b0; oe = 1'b0; we = 1'b0; addr = 6'h00; data_in = 8'h00; miso = 1'b1;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Reset values
        checkOutput("rst_sck", sck, 0);
        checkOutput("rst_mosi", mosi, 1);
        checkOutput("rst_ss_n", ss_n, 1);
        checkOutput("rst_irq", irq, 0);
        checkOutput("rst_idle_bus", data_out, 8'h00);
        readCheck("rst_spsr", 6'h01, 8'h00);
        readCheck("rst_spcr", 6'h02, 8'h01);
        readCheck("rst_spbr", 6'h03, 8'hFF);
        readCheck("rst_spdr", 6'h00, 8'h00);
        readCheck("unmapped_read", 6'h05, 8'h00);

        // Basic transfer at SPBR=1
        busWrite(6'h03, 8'h01);
        busWrite(6'h02, 8'h00);
        busWrite(6'h2A, 8'h77);
        checkOutput("ss_n_low", ss_n, 0);
        readCheck("unmapped_write_ignored", 6'h2A, 8'h00);
        expPeriod = 40;
        applyStimulus(8'hA5, 8'h3C);
        waitDone(32, "basic");
        checkOutput("basic_mosi_idle", mosi, 1);
        checkOutput("basic_sck_idle", sck, 0);
        readCheck("basic_spsr_done", 6'h01, 8'h80);
        checkRead("basic_spdr");
        readCheck("basic_spsr_clear", 6'h01, 8'h00);
        checkOutput("basic_irq_clear", irq, 0);

        // Fastest rate, miso held low
        busWrite(6'h03, 8'h00);
        expPeriod = 20;
        applyStimulus(8'hFF, 8'h00);
        waitDone(16, "fast");
        checkOutput("fast_mosi_idle", mosi, 1);
        checkRead("fast_spdr");

        // Collision: a second SPDR write mid-transfer is ignored and flags wcol
        busWrite(6'h03, 8'h03);
        expPeriod = 80;
        applyStimulus(8'h55, 8'h96);
        repeat (9) @(negedge clk);
        busWrite(6'h00, 8'hAA);
        waitDone(-1, "coll");
        readCheck("coll_spsr", 6'h01, 8'hC0);
        checkRead("coll_spdr");
        readCheck("coll_spsr_clear", 6'h01, 8'h00);

        // Back-to-back, then an SPDR read on the very edge the second transfer completes
        busWrite(6'h03, 8'h00);
        expPeriod = 20;
        applyStimulus(8'h12, 8'h34);
        waitDone(16, "b2b1");
        applyStimulus(8'h56, 8'h78);
        checkOutput("b2b_done_held", irq, 1);
        repeat (15) @(negedge clk);
        checkRead("b2b_first_spdr");
        checkOutput("b2b_set_wins", irq, 1);
        readCheck("b2b_spsr", 6'h01, 8'h80);
        checkRead("b2b_second_spdr");
        checkOutput("b2b_irq_clear", irq, 0);

        // Reset in the middle of a transfer
        busWrite(6'h03, 8'h01);
        expPeriod = 40;
        applyStimulus(8'hC3, 8'h5A);
        for (int i = 0; i < 200 && monBits < 4; i++) @(negedge clk);
        checkOutput("mid_reached_bit3", monBits, 4);
        nrst = 1'b0;
        #1;
        checkOutput("mid_rst_sck", sck, 0);
        checkOutput("mid_rst_mosi", mosi, 1);
        checkOutput("mid_rst_ss_n", ss_n, 1);
        checkOutput("mid_rst_irq", irq, 0);
        @(negedge clk);
        nrst = 1'b1;
        expTx.delete();
        expRx.delete();
        monBits = 0;
        @(negedge clk);
        readCheck("mid_spbr", 6'h03, 8'hFF);
        readCheck("mid_spdr", 6'h00, 8'h00);
        repeat (20) @(negedge clk);
        checkOutput("mid_no_irq", irq, 0);
        expPeriod = 5120;
        applyStimulus(8'h3E, 8'hE1);
        waitDone(4096, "post_rst");
        checkRead("post_rst_spdr");

        checkOutput("tx_queue_drained", expTx.size(), 0);
        checkOutput("rx_queue_drained", expRx.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/sd_spi_master.md
Name: sd_spi_master

Overview:
- Byte-wide SPI mode-0 master that drives the SD-card interface lines (sck, mosi, ss_n) and samples miso.
- Lets the CPU run SD transfers in hardware instead of bit-banging the port pins.
- Sits on the same 8-bit peripheral bus as the GPIO/UART block, decoded by its own cs.
- Its sck/mosi outputs feed the SD-card pin routing; that routing's miso output feeds this block's miso input.

Parameters:
- DIV_RESET, 8'hFF, reset value of the clock divider register (slowest rate, for SD init at ≤400 kHz).

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- data_out  output  8  read data; combinational, 8'h00 unless cs && oe
- data_in  input  8  write data
- addr  input  6  register address
- cs  input  1  block select
- oe  input  1  read strobe
- we  input  1  write strobe, sampled on posedge clk
- sck  output  1  SPI clock, idle low
- mosi  output  1  SPI data out, idle high
- miso  input  1  SPI data in
- ss_n  output  1  card chip select, software controlled
- irq  output  1  level, equals done flag

Behaviour:
- Register map:
  - 0x00 SPDR: write starts a transfer; read returns last received byte.
  - 0x01 SPSR, read-only: {done, wcol, 5'b0, busy}.
  - 0x02 SPCR: bit0 = ss_n, bits 7:1 read as 0.
  - 0x03 SPBR: divider. Half-period of sck = SPBR+1 clk cycles.
  - All other addresses read 8'h00; writes to them are ignored.
- Reset (async, nrst low): state IDLE, sck=0, mosi=1, ss_n=1, SPDR rx=8'h00, done=0, wcol=0, SPBR=DIV_RESET, bit counter=0, half-period counter=0.
- States:
  - IDLE: on cs&&we&&addr==0:
    - tx shift <= data_in;
    - mosi <= data_in[7];
    - bit_cnt <= 0;
    - cnt <= SPBR;
    - go to LOW.
  - LOW (sck=0): cnt decrements each cycle. At cnt==0:
    - sck <= 1;
    - rx shift <= {rx shift[6:0], miso};
    - cnt <= SPBR;
    - go to HIGH.
  - HIGH (sck=1): cnt decrements. At cnt==0:
    - sck <= 0;
    - if bit_cnt==7: SPDR rx <= rx shift; done <= 1; mosi <= 1; go to IDLE;
    - else: shift tx left; mosi <= next bit; bit_cnt+1; cnt <= SPBR; go to LOW.
- Transfer is MSB first, 8 bits.
- done rises exactly 16*(SPBR+1) clk edges after the write edge. For SPBR=0 that is 16 cycles and sck period is 2 clk.
- busy = (state != IDLE), combinational from state.
- SPBR is sampled at every cnt reload. Changing it mid-transfer takes effect at the next half period (software must not rely on this).
- Write to SPDR while busy: data ignored, transfer continues unchanged, wcol <= 1.
- Reading SPDR (cs&&oe&&addr==0) clears done and wcol on that clock edge.
  - If done or wcol is set on the same edge, the set wins.
- Write to SPCR takes effect next edge at any time, including mid-transfer; ss_n is not gated by the engine.
- A new transfer may start in the cycle after done rises; done stays set until SPDR is read.
- Reset asserted mid-transfer:
  - all outputs return to reset values immediately (async);
  - partial rx byte is discarded;
  - no done.
- miso is sampled by the clk edge that raises sck; no extra synchronizer latency.

Test Plan:
- Reset values: after reset, read 0x01→8'h00, 0x02→8'h01, 0x03→8'hFF; sck=0, mosi=1, ss_n=1, irq=0.
- Basic transfer: write SPBR=1, SPCR=0 (ss_n→0), SPDR=8'hA5; slave model returns 8'h3C.
  - Expect 8 sck pulses of period 4 clk.
  - mosi at rising edges = 1,0,1,0,0,1,0,1.
  - busy=1 throughout; done/irq rise at clock 32 after write.
  - SPSR=8'h80; SPDR read→8'h3C, then SPSR=8'h00.
- Fastest rate: SPBR=0, write 8'hFF with miso tied 0.
  - done at exactly 16 clocks; rx=8'h00; mosi returns to 1 after last fall.
- Collision: start 8'h55 at SPBR=3, write 8'hAA at clock 10.
  - Transmitted bits remain 0x55; SPSR after completion=8'hC0; one SPDR read clears to 8'h00.
- Back-to-back and simultaneous: read SPDR on the exact edge a second transfer completes.
  - done remains 1; next read clears it.
- Mid-transfer reset: pulse nrst low during bit 3.
  - sck=0, mosi=1, ss_n=1 immediately; SPBR=8'hFF; SPDR=8'h00; no irq; a new transfer then completes normally.
